// File: rtl/sched_pkg.sv
// Shared opcode/ALU constants, FSM state enum and decoded-instruction record
// for the dual-issue scheduler.
package sched_pkg;

   // Primary opcode in bits [15:13]
   localparam logic [2:0] OP_LDR  = 3'b011;
   localparam logic [2:0] OP_STR  = 3'b100;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   // ALU sub-op in bits [12:11]
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   // MOV form select in bit 12: 1 = immediate, 0 = register
   localparam logic MOV_IMM = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT0  = 3'd1,
      S_SECOND = 3'd2,
      S_WAIT1  = 3'd3,
      S_HALT   = 3'd4
   } sched_state_e;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] dest;
      logic       dest_v;
      logic [2:0] src1;
      logic       src1_v;
      logic [2:0] src2;
      logic       src2_v;
      logic       is_mem;
      logic       is_halt;
   } instr_info_t;

   // True when a valid destination matches a valid source register
   function automatic logic reg_hit(input logic [2:0] d, input logic dv,
                                    input logic [2:0] s, input logic sv);
      return dv & sv & (d == s);
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Per-instruction decode: class, destination, sources, memory and HALT flags.
module instr_class_decode
   import sched_pkg::*;
#(
   parameter int ILEN = 16
) (
   input  logic [ILEN-1:0] ir,
   output instr_info_t     info
);

   // Bits [4:3] carry no register field in any format
   logic unused_bits_s;
   assign unused_bits_s = &{1'b0, ir[4:3]};

   // Field extraction by opcode class
   always_comb begin
      info    = '0;
      info.op = ir[15:13];
      case (ir[15:13])
         OP_LDR: begin
            info.dest   = ir[7:5];
            info.dest_v = 1'b1;
            info.src1   = ir[10:8];
            info.src1_v = 1'b1;
            info.is_mem = 1'b1;
         end
         OP_STR: begin
            info.src1   = ir[10:8];
            info.src1_v = 1'b1;
            info.src2   = ir[7:5];
            info.src2_v = 1'b1;
            info.is_mem = 1'b1;
         end
         OP_ALU: begin
            info.dest   = ir[7:5];
            info.src2   = ir[2:0];
            info.src2_v = 1'b1;
            info.src1   = ir[10:8];
            // CMP only sets flags; MVN has no Rn operand
            if (ir[12:11] == ALU_CMP) begin
               info.dest_v = 1'b0;
            end else begin
               info.dest_v = 1'b1;
            end
            if (ir[12:11] == ALU_MVN) begin
               info.src1_v = 1'b0;
            end else begin
               info.src1_v = 1'b1;
            end
         end
         OP_MOV: begin
            info.dest_v = 1'b1;
            if (ir[12] == MOV_IMM) begin
               info.dest = ir[10:8];
            end else begin
               info.dest   = ir[7:5];
               info.src2   = ir[2:0];
               info.src2_v = 1'b1;
            end
         end
         OP_HALT: begin
            info.is_halt = 1'b1;
         end
         default: begin
            info.is_halt = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: issues an instruction pair together when independent,
// otherwise serially, sequencing the single data-memory port.
module dual_issue_scheduler
   import sched_pkg::*;
#(
   parameter int ILEN  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pair_valid,
   input  logic [ILEN-1:0]  p0_ir,
   input  logic [ILEN-1:0]  p1_ir,
   input  logic             mem_ack,
   output logic             issue0,
   output logic             issue1,
   output logic             mem_req,
   output logic             mem_sel,
   output logic             fetch_next,
   output logic             halted,
   output logic [CNT_W-1:0] split_count
);

   sched_state_e     state_r;
   logic [ILEN-1:0]  p1_cap_r;
   logic             mem_sel_r;
   logic             halted_r;
   logic [CNT_W-1:0] split_r;

   logic [ILEN-1:0]  p1_src_s;
   instr_info_t      p0_info_s;
   instr_info_t      p1_info_s;
   logic             conflict_s;
   logic             one_mem_s;
   logic             issue0_s;
   logic             issue1_s;
   logic             fetch_s;
   logic             mem_req_s;

   // Outside IDLE only the captured p1 matters, so live p1_ir cannot leak in
   assign p1_src_s = (state_r == S_IDLE) ? p1_ir : p1_cap_r;

   instr_class_decode #(.ILEN(ILEN)) u_dec_p0 (.ir(p0_ir),    .info(p0_info_s));
   instr_class_decode #(.ILEN(ILEN)) u_dec_p1 (.ir(p1_src_s), .info(p1_info_s));

   // Pair hazard detection: RAW, WAW, shared memory port, leading HALT
   always_comb begin
      conflict_s = reg_hit(p0_info_s.dest, p0_info_s.dest_v, p1_info_s.src1, p1_info_s.src1_v)
                 | reg_hit(p0_info_s.dest, p0_info_s.dest_v, p1_info_s.src2, p1_info_s.src2_v)
                 | reg_hit(p0_info_s.dest, p0_info_s.dest_v, p1_info_s.dest, p1_info_s.dest_v)
                 | (p0_info_s.is_mem & p1_info_s.is_mem)
                 | p0_info_s.is_halt;
      one_mem_s  = p0_info_s.is_mem ^ p1_info_s.is_mem;
   end

   // Issue/fetch pulses and memory request decoded from state and inputs
   always_comb begin
      issue0_s  = 1'b0;
      issue1_s  = 1'b0;
      fetch_s   = 1'b0;
      mem_req_s = 1'b0;
      if (reset) begin
         issue0_s = 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (pair_valid) begin
                  issue0_s = 1'b1;
                  if (!conflict_s) begin
                     issue1_s = 1'b1;
                     fetch_s  = ~one_mem_s & ~p1_info_s.is_halt;
                  end else begin
                     issue1_s = 1'b0;
                  end
               end else begin
                  issue0_s = 1'b0;
               end
            end
            S_WAIT0:  mem_req_s = 1'b1;
            S_SECOND: begin
               issue1_s = 1'b1;
               fetch_s  = ~p1_info_s.is_mem & ~p1_info_s.is_halt;
            end
            S_WAIT1: begin
               mem_req_s = 1'b1;
               fetch_s   = mem_ack;
            end
            S_HALT:   issue0_s = 1'b0;
            default:  issue0_s = 1'b0;
         endcase
      end
   end

   // Scheduler FSM with capture register, memory-port owner and split counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_IDLE;
         p1_cap_r  <= '0;
         mem_sel_r <= 1'b0;
         halted_r  <= 1'b0;
         split_r   <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (pair_valid && !conflict_s) begin
                  if (one_mem_s) begin
                     mem_sel_r <= ~p0_info_s.is_mem;
                     state_r   <= S_WAIT1;
                  end else if (p1_info_s.is_halt) begin
                     halted_r  <= 1'b1;
                     state_r   <= S_HALT;
                  end else begin
                     state_r   <= S_IDLE;
                  end
               end else if (pair_valid) begin
                  p1_cap_r <= p1_ir;
                  if (split_r != {CNT_W{1'b1}}) begin
                     split_r <= split_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
                  if (p0_info_s.is_halt) begin
                     halted_r  <= 1'b1;
                     state_r   <= S_HALT;
                  end else if (p0_info_s.is_mem) begin
                     mem_sel_r <= 1'b0;
                     state_r   <= S_WAIT0;
                  end else begin
                     state_r   <= S_SECOND;
                  end
               end
            end
            S_WAIT0: begin
               mem_sel_r <= 1'b0;
               if (mem_ack) begin
                  state_r <= S_SECOND;
               end
            end
            S_SECOND: begin
               if (p1_info_s.is_mem) begin
                  mem_sel_r <= 1'b1;
                  state_r   <= S_WAIT1;
               end else if (p1_info_s.is_halt) begin
                  halted_r  <= 1'b1;
                  state_r   <= S_HALT;
               end else begin
                  state_r   <= S_IDLE;
               end
            end
            S_WAIT1: begin
               if (mem_ack) begin
                  state_r <= S_IDLE;
               end
            end
            S_HALT: begin
               halted_r <= 1'b1;
               state_r  <= S_HALT;
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   assign issue0      = issue0_s;
   assign issue1      = issue1_s;
   assign fetch_next  = fetch_s;
   assign mem_req     = mem_req_s;
   assign mem_sel     = mem_sel_r & ~reset;
   assign halted      = halted_r;
   assign split_count = split_r;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed self-checking bench for dual_issue_scheduler.
module tb_dual_issue_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        pair_valid;
   logic [15:0] p0_ir;
   logic [15:0] p1_ir;
   logic        mem_ack;
   logic        issue0, issue1, mem_req, mem_sel, fetch_next, halted;
   logic [7:0]  split_count;

   int total = 0;
   int bad   = 0;

   // Hand-encoded instructions
   localparam logic [15:0] MOV_R0_5   = 16'hD005;
   localparam logic [15:0] MOV_R1_7   = 16'hD107;
   localparam logic [15:0] MOV_R0_1   = 16'hD001;
   localparam logic [15:0] STR_R1_R1  = 16'h8120;
   localparam logic [15:0] LDR_R3_R1  = 16'h6160;
   localparam logic [15:0] ADD_R4_1_2 = 16'hA182;
   localparam logic [15:0] STR_R4_R1  = 16'h8180;
   localparam logic [15:0] ADD_R5_4_0 = 16'hA4A0;
   localparam logic [15:0] HALT_I     = 16'hE000;

   dual_issue_scheduler #(.ILEN(16), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .pair_valid  (pair_valid),
      .p0_ir       (p0_ir),
      .p1_ir       (p1_ir),
      .mem_ack     (mem_ack),
      .issue0      (issue0),
      .issue1      (issue1),
      .mem_req     (mem_req),
      .mem_sel     (mem_sel),
      .fetch_next  (fetch_next),
      .halted      (halted),
      .split_count (split_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // issue0, issue1, fetch_next, mem_req as one vector
   task automatic chk_pulses(input string tag, input logic [3:0] exp);
      #1;
      chk(tag, {28'd0, issue0, issue1, fetch_next, mem_req}, {28'd0, exp});
   endtask

   initial begin
      reset = 1'b1; pair_valid = 1'b1; p0_ir = MOV_R0_5; p1_ir = MOV_R1_7; mem_ack = 1'b0;
      tick(); tick();
      // Outputs held low while reset is high, even with a valid pair
      chk_pulses("reset_pulses", 4'b0000);
      chk("reset_memsel", {31'd0, mem_sel}, 32'd0);
      chk("reset_split", {24'd0, split_count}, 32'd0);
      chk("reset_halted", {31'd0, halted}, 32'd0);

      // Independent MOV pair: dual issue plus fetch in one cycle
      reset = 1'b0;
      chk_pulses("mov_dual", 4'b1110);
      tick();
      pair_valid = 1'b0;
      chk_pulses("mov_after", 4'b0000);
      chk("mov_split", {24'd0, split_count}, 32'd0);

      // STR/LDR: both memory ops, serial with two 2-cycle waits
      pair_valid = 1'b1; p0_ir = STR_R1_R1; p1_ir = LDR_R3_R1;
      chk_pulses("mm_issue0", 4'b1000);
      tick();
      pair_valid = 1'b0; p1_ir = MOV_R0_1;
      chk_pulses("mm_wait0_c1", 4'b0001);
      chk("mm_wait0_sel", {31'd0, mem_sel}, 32'd0);
      tick();
      mem_ack = 1'b1;
      chk_pulses("mm_wait0_c2", 4'b0001);
      tick();
      mem_ack = 1'b0;
      chk_pulses("mm_second", 4'b0100);
      tick();
      chk_pulses("mm_wait1_c1", 4'b0001);
      chk("mm_wait1_sel", {31'd0, mem_sel}, 32'd1);
      tick();
      mem_ack = 1'b1;
      chk_pulses("mm_wait1_c2", 4'b0011);
      tick();
      mem_ack = 1'b0;
      chk_pulses("mm_idle", 4'b0000);
      chk("mm_split", {24'd0, split_count}, 32'd1);

      // ADD/STR RAW: p1 captured, live p1_ir swapped to a non-memory op
      pair_valid = 1'b1; p0_ir = ADD_R4_1_2; p1_ir = STR_R4_R1;
      chk_pulses("raw_issue0", 4'b1000);
      tick();
      pair_valid = 1'b0; p1_ir = MOV_R0_1;
      chk_pulses("raw_second", 4'b0100);
      tick();
      mem_ack = 1'b1;
      chk_pulses("raw_wait1_ack", 4'b0011);
      chk("raw_wait1_sel", {31'd0, mem_sel}, 32'd1);
      tick();
      mem_ack = 1'b0;
      chk_pulses("raw_idle", 4'b0000);
      chk("raw_split", {24'd0, split_count}, 32'd2);

      // HALT first: issue0 only, then stuck halted despite pair_valid
      pair_valid = 1'b1; p0_ir = HALT_I; p1_ir = MOV_R0_1;
      chk_pulses("halt_issue0", 4'b1000);
      tick();
      for (int i = 0; i < 10; i++) begin
         mem_ack = (i == 3);
         chk_pulses("halt_quiet", 4'b0000);
         chk("halt_flag", {31'd0, halted}, 32'd1);
         tick();
      end
      mem_ack = 1'b0;
      chk("halt_split", {24'd0, split_count}, 32'd3);

      // Reset in WAIT0 abandons the access; a late ack is ignored
      reset = 1'b1; pair_valid = 1'b0;
      tick();
      reset = 1'b0;
      chk("rst_halted_clr", {31'd0, halted}, 32'd0);
      pair_valid = 1'b1; p0_ir = STR_R1_R1; p1_ir = LDR_R3_R1;
      chk_pulses("rw_issue0", 4'b1000);
      tick();
      pair_valid = 1'b0;
      chk_pulses("rw_wait0", 4'b0001);
      reset = 1'b1;
      chk_pulses("rw_in_reset", 4'b0000);
      tick();
      reset = 1'b0; mem_ack = 1'b1;
      chk_pulses("rw_late_ack", 4'b0000);
      chk("rw_split_clr", {24'd0, split_count}, 32'd0);
      tick();
      mem_ack = 1'b0;
      chk_pulses("rw_idle", 4'b0000);
      pair_valid = 1'b1; p0_ir = MOV_R0_5; p1_ir = MOV_R1_7;
      chk_pulses("rw_next_pair", 4'b1110);
      tick();
      pair_valid = 1'b0;

      // Split counter saturation with 256 conflicting ALU pairs
      reset = 1'b1;
      tick();
      reset = 1'b0;
      p0_ir = ADD_R4_1_2; p1_ir = ADD_R5_4_0;
      for (int n = 1; n <= 256; n++) begin
         pair_valid = 1'b1;
         tick();
         pair_valid = 1'b0;
         tick();
         if (n == 254) chk("sat_254", {24'd0, split_count}, 32'd254);
         if (n == 255) chk("sat_255", {24'd0, split_count}, 32'd255);
      end
      chk("sat_256", {24'd0, split_count}, 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
